video_pattern_gen: RTL and testbench
====================================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter COLOR_BITS, default 3, meaning bits per colour channel (1..8).
REQ-002 SHALL have parameter H_VISIBLE, default 640, meaning visible pixels per line.
REQ-003 SHALL have parameter V_VISIBLE, default 480, meaning visible lines per frame.
REQ-004 SHALL have parameter POS_BITS, default 10, meaning width of position inputs.
REQ-005 SHALL have parameter BORDER_WIDTH, default 8, meaning border thickness in pixels.
REQ-006 SHALL have parameter BOX_SIZE, default 32, meaning bouncing-box edge in pixels.
REQ-007 SHALL have parameter BOX_STEP, default 2, meaning box pixels moved per frame.
REQ-008 SHALL have ports: i_clk in 1 pixel clock; i_rst_n in 1 async active-low reset.
REQ-009 SHALL have ports: i_pattern in 4 requested pattern; i_hpos in POS_BITS column; i_vpos in POS_BITS row; i_visible in 1 active area; i_frame_strobe in 1 one-cycle frame start.
REQ-010 SHALL have ports: i_scroll_en in 1 enable scrolling; i_scroll_dir in 1 scroll direction (0 down, 1 up).
REQ-011 SHALL have ports: o_red, o_grn, o_blu out COLOR_BITS each; o_visible out 1 delayed i_visible; o_active_pattern out 4 currently latched pattern.

Function
REQ-012 SHALL sample i_pattern into the active-pattern register only on cycles with i_frame_strobe=1; o_active_pattern SHALL reflect it.
REQ-013 SHALL register all colour outputs and o_visible with exactly 1 cycle latency from i_hpos/i_vpos/i_visible.
REQ-014 SHALL drive colour 0 whenever the delayed visible is 0, regardless of pattern.
REQ-015 SHALL define patterns: 0 black; 1 red full-scale; 2 green; 3 blue; 4 eight vertical bars of H_VISIBLE/8 (bar n: R=~n[1], G=~n[2], B=~n[0], full-scale); 5 full-scale white border BORDER_WIDTH wide on all four edges, black inside; 6 grey sawtooth ramp, all channels = i_hpos[COLOR_BITS+3:4]; 7 scrolling horizontal bars; 8 bouncing white box on black; 9-15 black.
REQ-016 SHALL, for pattern 7, compute row = (i_vpos + offset) mod V_VISIBLE without overflow, bar = row/(V_VISIBLE/8), colour mapping R=n[1], G=n[2], B=n[0].
REQ-017 SHALL update offset only on i_frame_strobe with i_scroll_en=1: dir 0 increments, wrapping V_VISIBLE-1 -> 0; dir 1 decrements, wrapping 0 -> V_VISIBLE-1; offset holds otherwise.
REQ-018 SHALL keep box X in [0, H_VISIBLE-BOX_SIZE] and Y in [0, V_VISIBLE-BOX_SIZE]; pixel inside when X<=hpos<X+BOX_SIZE and Y<=vpos<Y+BOX_SIZE.
REQ-019 SHALL implement per-axis FSM states INC and DEC, advancing only on i_frame_strobe: INC adds BOX_STEP; if result exceeds the maximum, clamp to the maximum and enter DEC; DEC subtracts BOX_STEP; if result would go below 0, clamp to 0 and enter INC.
REQ-020 SHALL, on a cycle with simultaneous i_frame_strobe and pattern change, output that cycle's pixel using the previous pattern, new pattern from the following pixel.
REQ-021 SHALL scale full-scale colours as all-ones of COLOR_BITS.

Reset
REQ-022 SHALL, while i_rst_n=0, asynchronously clear outputs, active pattern (0), offset (0), box X/Y (0), both axis FSMs to INC.
REQ-023 SHALL resume normal operation on the first i_clk edge after i_rst_n deasserts, including reset asserted mid-frame.

Configuration
REQ-024 SHALL gate the bouncing box with macro VIDEO_PATTERN_GEN_BOX_EN: defined -> pattern 8 as REQ-018/019; undefined -> box registers and FSM absent, pattern 8 outputs black.

Structure
REQ-025 SHALL place pattern-ID constants (PAT_OFF..PAT_BOX) and the axis FSM state type in shared package video_pattern_pkg.
REQ-026 SHALL implement one axis of the box as sub-module video_pattern_bounce_axis (params LIMIT, STEP), instantiated twice.

Verification
REQ-027 Pattern 4, hpos=85, visible -> next cycle R=7,G=7,B=0 (bar 1).
REQ-028 i_pattern 2->5 mid-frame without strobe -> output stays green until next strobe; then hpos=3 -> 7,7,7; hpos=320,vpos=240 -> 0,0,0.
REQ-029 Pattern 7, scroll_en=1, dir=1, offset 0, one strobe -> offset=479; vpos=0 now maps to bar 7 (7,7,7).
REQ-030 Box enabled, X=606, INC, strobe -> X=608 DEC; next strobe -> X=606; macro undefined -> pattern 8 all zeros.
REQ-031 Assert i_rst_n=0 mid-line with pattern 1 -> outputs 0 immediately, o_active_pattern=0; release -> black until next strobe.

Source files
------------

// File: rtl/video_pattern_pkg.sv
// Shared pattern IDs and bouncing-box axis state type for the video pattern generator.
package video_pattern_pkg;

  localparam logic [3:0] PAT_OFF    = 4'd0;
  localparam logic [3:0] PAT_RED    = 4'd1;
  localparam logic [3:0] PAT_GREEN  = 4'd2;
  localparam logic [3:0] PAT_BLUE   = 4'd3;
  localparam logic [3:0] PAT_BARS   = 4'd4;
  localparam logic [3:0] PAT_BORDER = 4'd5;
  localparam logic [3:0] PAT_RAMP   = 4'd6;
  localparam logic [3:0] PAT_SCROLL = 4'd7;
  localparam logic [3:0] PAT_BOX    = 4'd8;

  typedef enum logic {
    AXIS_INC = 1'b0,
    AXIS_DEC = 1'b1
  } axis_state_t;

endpackage

// File: rtl/video_pattern_bounce_axis.sv
// One axis of the bouncing box: position ping-pongs between 0 and LIMIT, one step per frame.
module video_pattern_bounce_axis
  import video_pattern_pkg::*;
#(
  parameter int POS_BITS = 10,
  parameter int LIMIT    = 608,
  parameter int STEP     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance,
  output logic [POS_BITS-1:0] pos
);

  localparam logic [POS_BITS:0] LIMIT_W = (POS_BITS+1)'(LIMIT);
  localparam logic [POS_BITS:0] STEP_W  = (POS_BITS+1)'(STEP);

  axis_state_t       state;
  logic [POS_BITS:0] pos_ext;

  assign pos_ext = {1'b0, pos};

  // Reaching either end clamps there and turns around, so the box never stalls at an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos   <= '0;
      state <= AXIS_INC;
    end else if (advance) begin
      case (state)
        AXIS_INC: begin
          if (pos_ext + STEP_W >= LIMIT_W) begin
            pos   <= LIMIT_W[POS_BITS-1:0];
            state <= AXIS_DEC;
          end else begin
            pos <= pos + STEP_W[POS_BITS-1:0];
          end
        end
        AXIS_DEC: begin
          if (pos_ext <= STEP_W) begin
            pos   <= '0;
            state <= AXIS_INC;
          end else begin
            pos <= pos - STEP_W[POS_BITS-1:0];
          end
        end
        default: state <= AXIS_INC;
      endcase
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern generator with one-cycle registered colour output.
// Define VIDEO_PATTERN_GEN_BOX_EN to build the bouncing-box pattern (8); otherwise pattern 8 is black.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int COLOR_BITS   = 3,
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int POS_BITS     = 10,
  parameter int BORDER_WIDTH = 8,
  parameter int BOX_SIZE     = 32,
  parameter int BOX_STEP     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [3:0]            i_pattern,
  input  logic [POS_BITS-1:0]   i_hpos,
  input  logic [POS_BITS-1:0]   i_vpos,
  input  logic                  i_visible,
  input  logic                  i_frame_strobe,
  input  logic                  i_scroll_en,
  input  logic                  i_scroll_dir,
  output logic [COLOR_BITS-1:0] o_red,
  output logic [COLOR_BITS-1:0] o_grn,
  output logic [COLOR_BITS-1:0] o_blu,
  output logic                  o_visible,
  output logic [3:0]            o_active_pattern
);

  localparam int                    BAR_W  = H_VISIBLE / 8;
  localparam int                    ROW_H  = V_VISIBLE / 8;
  localparam logic [POS_BITS-1:0]   V_LAST = POS_BITS'(V_VISIBLE - 1);
  localparam logic [POS_BITS:0]     V_EXT  = (POS_BITS+1)'(V_VISIBLE);
  localparam logic [COLOR_BITS-1:0] FULL   = '1;

  logic [POS_BITS-1:0]   offset;
  logic [POS_BITS:0]     row_sum;
  logic [POS_BITS:0]     row;
  logic [2:0]            hbar;
  logic [2:0]            vbar;
  logic                  in_border;
  logic [COLOR_BITS-1:0] pix_r, pix_g, pix_b;

  assign hbar    = 3'(i_hpos / POS_BITS'(BAR_W));
  assign row_sum = {1'b0, i_vpos} + {1'b0, offset};
  assign row     = (row_sum >= V_EXT) ? row_sum - V_EXT : row_sum;
  assign vbar    = 3'(row / (POS_BITS+1)'(ROW_H));

  assign in_border = (i_hpos <  POS_BITS'(BORDER_WIDTH)) ||
                     (i_hpos >= POS_BITS'(H_VISIBLE - BORDER_WIDTH)) ||
                     (i_vpos <  POS_BITS'(BORDER_WIDTH)) ||
                     (i_vpos >= POS_BITS'(V_VISIBLE - BORDER_WIDTH));

`ifdef VIDEO_PATTERN_GEN_BOX_EN
  logic [POS_BITS-1:0] box_x;
  logic [POS_BITS-1:0] box_y;
  logic                in_box;

  video_pattern_bounce_axis #(
    .POS_BITS (POS_BITS),
    .LIMIT    (H_VISIBLE - BOX_SIZE),
    .STEP     (BOX_STEP)
  ) u_axis_x (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .advance (i_frame_strobe),
    .pos     (box_x)
  );

  video_pattern_bounce_axis #(
    .POS_BITS (POS_BITS),
    .LIMIT    (V_VISIBLE - BOX_SIZE),
    .STEP     (BOX_STEP)
  ) u_axis_y (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .advance (i_frame_strobe),
    .pos     (box_y)
  );

  assign in_box = ({1'b0, i_hpos} >= {1'b0, box_x}) &&
                  ({1'b0, i_hpos} <  {1'b0, box_x} + (POS_BITS+1)'(BOX_SIZE)) &&
                  ({1'b0, i_vpos} >= {1'b0, box_y}) &&
                  ({1'b0, i_vpos} <  {1'b0, box_y} + (POS_BITS+1)'(BOX_SIZE));
`endif

  // Pixel colour uses the pattern latched before this edge, so a strobe cycle still shows the old pattern.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (o_active_pattern)
      PAT_RED:   pix_r = FULL;
      PAT_GREEN: pix_g = FULL;
      PAT_BLUE:  pix_b = FULL;
      PAT_BARS: begin
        pix_r = {COLOR_BITS{~hbar[1]}};
        pix_g = {COLOR_BITS{~hbar[2]}};
        pix_b = {COLOR_BITS{~hbar[0]}};
      end
      PAT_BORDER: begin
        pix_r = {COLOR_BITS{in_border}};
        pix_g = {COLOR_BITS{in_border}};
        pix_b = {COLOR_BITS{in_border}};
      end
      PAT_RAMP: begin
        pix_r = i_hpos[COLOR_BITS+3:4];
        pix_g = i_hpos[COLOR_BITS+3:4];
        pix_b = i_hpos[COLOR_BITS+3:4];
      end
      PAT_SCROLL: begin
        pix_r = {COLOR_BITS{vbar[1]}};
        pix_g = {COLOR_BITS{vbar[2]}};
        pix_b = {COLOR_BITS{vbar[0]}};
      end
`ifdef VIDEO_PATTERN_GEN_BOX_EN
      PAT_BOX: begin
        pix_r = {COLOR_BITS{in_box}};
        pix_g = {COLOR_BITS{in_box}};
        pix_b = {COLOR_BITS{in_box}};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_red     <= '0;
      o_grn     <= '0;
      o_blu     <= '0;
      o_visible <= 1'b0;
    end else begin
      o_visible <= i_visible;
      o_red     <= i_visible ? pix_r : '0;
      o_grn     <= i_visible ? pix_g : '0;
      o_blu     <= i_visible ? pix_b : '0;
    end
  end

  // Pattern and scroll offset only change at frame boundaries to avoid mid-frame tearing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_active_pattern <= PAT_OFF;
      offset           <= '0;
    end else if (i_frame_strobe) begin
      o_active_pattern <= i_pattern;
      if (i_scroll_en) begin
        if (!i_scroll_dir) begin
          offset <= (offset == V_LAST) ? '0 : offset + 1'b1;
        end else begin
          offset <= (offset == '0) ? V_LAST : offset - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed self-checking bench for video_pattern_gen (default parameters); follows VIDEO_PATTERN_GEN_BOX_EN.
module tb_video_pattern_gen;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_pattern = 4'd0;
  logic [9:0] i_hpos = '0;
  logic [9:0] i_vpos = '0;
  logic       i_visible = 1'b0;
  logic       i_frame_strobe = 1'b0;
  logic       i_scroll_en = 1'b0;
  logic       i_scroll_dir = 1'b0;
  logic [2:0] o_red, o_grn, o_blu;
  logic       o_visible;
  logic [3:0] o_active_pattern;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_count = 0;

  typedef struct {
    logic [3:0] pat;
    int         h;
    int         v;
    logic       vis;
    logic       strobe;
    int         er;
    int         eg;
    int         eb;
    logic [3:0] act;
  } vec_t;

  vec_t vecs[$];

  video_pattern_gen dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pattern        (i_pattern),
    .i_hpos           (i_hpos),
    .i_vpos           (i_vpos),
    .i_visible        (i_visible),
    .i_frame_strobe   (i_frame_strobe),
    .i_scroll_en      (i_scroll_en),
    .i_scroll_dir     (i_scroll_dir),
    .o_red            (o_red),
    .o_grn            (o_grn),
    .o_blu            (o_blu),
    .o_visible        (o_visible),
    .o_active_pattern (o_active_pattern)
  );

  always #5 i_clk = ~i_clk;

  task automatic apply_stimulus(input logic [3:0] pat, input int h, input int v,
                                input logic vis, input logic strobe);
    i_pattern      = pat;
    i_hpos         = 10'(h);
    i_vpos         = 10'(v);
    i_visible      = vis;
    i_frame_strobe = strobe;
    @(posedge i_clk);
    #1;
    if (strobe) strobe_count++;
    i_frame_strobe = 1'b0;
  endtask

  task automatic check_output(input string name, input int er, input int eg, input int eb,
                              input logic ev, input logic [3:0] eact);
    n_checks++;
    if (o_red !== 3'(er) || o_grn !== 3'(eg) || o_blu !== 3'(eb) ||
        o_visible !== ev || o_active_pattern !== eact) begin
      n_fail++;
      $display("[TB] FAIL %s: got rgb=%0d,%0d,%0d vis=%b pat=%0d, expected rgb=%0d,%0d,%0d vis=%b pat=%0d",
               name, o_red, o_grn, o_blu, o_visible, o_active_pattern, er, eg, eb, ev, eact);
    end
  endtask

  function automatic void add_vec(input logic [3:0] pat, input int h, input int v, input logic vis,
                                  input logic strobe, input int er, input int eg, input int eb,
                                  input logic [3:0] act);
    vec_t t;
    t.pat = pat; t.h = h; t.v = v; t.vis = vis; t.strobe = strobe;
    t.er = er; t.eg = eg; t.eb = eb; t.act = act;
    vecs.push_back(t);
  endfunction

  initial begin
    // Solid colours and the old-pattern-on-strobe-cycle rule
    add_vec(4'd1, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd1);
    add_vec(4'd1, 10, 10, 1'b1, 1'b0, 7, 0, 0, 4'd1);
    add_vec(4'd2, 10, 10, 1'b1, 1'b1, 7, 0, 0, 4'd2);
    add_vec(4'd2, 10, 10, 1'b1, 1'b0, 0, 7, 0, 4'd2);
    add_vec(4'd3, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd3);
    add_vec(4'd3, 20, 30, 1'b1, 1'b0, 0, 0, 7, 4'd3);
    // Vertical bars
    add_vec(4'd4, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd4);
    add_vec(4'd4, 85, 10, 1'b1, 1'b0, 7, 7, 0, 4'd4);
    add_vec(4'd4, 0, 10, 1'b1, 1'b0, 7, 7, 7, 4'd4);
    add_vec(4'd4, 639, 10, 1'b1, 1'b0, 0, 0, 0, 4'd4);
    add_vec(4'd4, 400, 10, 1'b1, 1'b0, 7, 0, 0, 4'd4);
    add_vec(4'd4, 479, 10, 1'b1, 1'b0, 7, 0, 0, 4'd4);
    add_vec(4'd4, 480, 10, 1'b1, 1'b0, 0, 0, 7, 4'd4);
    add_vec(4'd4, 85, 10, 1'b0, 1'b0, 0, 0, 0, 4'd4);
    // Pattern request without strobe is ignored, then border
    add_vec(4'd2, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd2);
    add_vec(4'd5, 3, 100, 1'b1, 1'b0, 0, 7, 0, 4'd2);
    add_vec(4'd5, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd5);
    add_vec(4'd5, 3, 100, 1'b1, 1'b0, 7, 7, 7, 4'd5);
    add_vec(4'd5, 320, 240, 1'b1, 1'b0, 0, 0, 0, 4'd5);
    add_vec(4'd5, 7, 240, 1'b1, 1'b0, 7, 7, 7, 4'd5);
    add_vec(4'd5, 8, 240, 1'b1, 1'b0, 0, 0, 0, 4'd5);
    add_vec(4'd5, 631, 240, 1'b1, 1'b0, 0, 0, 0, 4'd5);
    add_vec(4'd5, 632, 240, 1'b1, 1'b0, 7, 7, 7, 4'd5);
    add_vec(4'd5, 320, 471, 1'b1, 1'b0, 0, 0, 0, 4'd5);
    add_vec(4'd5, 320, 472, 1'b1, 1'b0, 7, 7, 7, 4'd5);
    // Grey ramp
    add_vec(4'd6, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd6);
    add_vec(4'd6, 53, 5, 1'b1, 1'b0, 3, 3, 3, 4'd6);
    add_vec(4'd6, 127, 5, 1'b1, 1'b0, 7, 7, 7, 4'd6);
    add_vec(4'd6, 128, 5, 1'b1, 1'b0, 0, 0, 0, 4'd6);
    add_vec(4'd6, 421, 5, 1'b1, 1'b0, 2, 2, 2, 4'd6);
    // Horizontal bars, offset 0
    add_vec(4'd7, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd7);
    add_vec(4'd7, 10, 0, 1'b1, 1'b0, 0, 0, 0, 4'd7);
    add_vec(4'd7, 10, 60, 1'b1, 1'b0, 0, 0, 7, 4'd7);
    add_vec(4'd7, 10, 130, 1'b1, 1'b0, 7, 0, 0, 4'd7);
    add_vec(4'd7, 10, 479, 1'b1, 1'b0, 7, 7, 7, 4'd7);
    // Undefined patterns and black
    add_vec(4'd9, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd9);
    add_vec(4'd9, 10, 10, 1'b1, 1'b0, 0, 0, 0, 4'd9);
    add_vec(4'd15, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd15);
    add_vec(4'd15, 10, 10, 1'b1, 1'b0, 0, 0, 0, 4'd15);
    add_vec(4'd0, 0, 0, 1'b0, 1'b1, 0, 0, 0, 4'd0);
    add_vec(4'd0, 10, 10, 1'b1, 1'b0, 0, 0, 0, 4'd0);

    // Reset state with inputs that would otherwise produce colour
    i_pattern = 4'd1; i_visible = 1'b1; i_frame_strobe = 1'b1; i_hpos = 10'd10;
    #22;
    check_output("reset_state", 0, 0, 0, 1'b0, 4'd0);
    i_frame_strobe = 1'b0; i_visible = 1'b0;
    i_rst_n = 1'b1;
    #3;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].pat, vecs[i].h, vecs[i].v, vecs[i].vis, vecs[i].strobe);
      check_output($sformatf("vec%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb,
                   vecs[i].vis, vecs[i].act);
    end

    // Scrolling: upward from offset 0 wraps to 479
    i_scroll_en = 1'b1; i_scroll_dir = 1'b1;
    apply_stimulus(4'd7, 0, 0, 1'b0, 1'b1);
    i_scroll_en = 1'b0;
    apply_stimulus(4'd7, 10, 0, 1'b1, 1'b0);
    check_output("scroll_up_wrap_v0", 7, 7, 7, 1'b1, 4'd7);
    apply_stimulus(4'd7, 10, 1, 1'b1, 1'b0);
    check_output("scroll_up_wrap_v1", 0, 0, 0, 1'b1, 4'd7);
    // Downward from 479 wraps to 0, then to 1
    i_scroll_en = 1'b1; i_scroll_dir = 1'b0;
    apply_stimulus(4'd7, 0, 0, 1'b0, 1'b1);
    i_scroll_en = 1'b0;
    apply_stimulus(4'd7, 10, 479, 1'b1, 1'b0);
    check_output("scroll_down_wrap_v479", 7, 7, 7, 1'b1, 4'd7);
    i_scroll_en = 1'b1;
    apply_stimulus(4'd7, 0, 0, 1'b0, 1'b1);
    i_scroll_en = 1'b0;
    apply_stimulus(4'd7, 10, 59, 1'b1, 1'b0);
    check_output("scroll_off1_v59", 0, 0, 7, 1'b1, 4'd7);
    apply_stimulus(4'd7, 10, 479, 1'b1, 1'b0);
    check_output("scroll_off1_v479_mod", 0, 0, 0, 1'b1, 4'd7);
    apply_stimulus(4'd7, 0, 0, 1'b0, 1'b1);
    apply_stimulus(4'd7, 10, 59, 1'b1, 1'b0);
    check_output("scroll_hold_no_en", 0, 0, 7, 1'b1, 4'd7);

    // Asynchronous reset mid-line while showing red
    apply_stimulus(4'd1, 0, 0, 1'b0, 1'b1);
    apply_stimulus(4'd1, 100, 50, 1'b1, 1'b0);
    check_output("pre_reset_red", 7, 0, 0, 1'b1, 4'd1);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_output("async_reset_clear", 0, 0, 0, 1'b0, 4'd0);
    #3;
    i_rst_n = 1'b1;
    strobe_count = 0;
    apply_stimulus(4'd1, 101, 50, 1'b1, 1'b0);
    check_output("post_reset_black", 0, 0, 0, 1'b1, 4'd0);
    apply_stimulus(4'd1, 102, 50, 1'b1, 1'b1);
    check_output("post_reset_strobe_cycle", 0, 0, 0, 1'b1, 4'd1);
    apply_stimulus(4'd1, 103, 50, 1'b1, 1'b0);
    check_output("post_reset_red", 7, 0, 0, 1'b1, 4'd1);
    apply_stimulus(4'd7, 0, 0, 1'b0, 1'b1);
    apply_stimulus(4'd7, 10, 479, 1'b1, 1'b0);
    check_output("offset_cleared_by_reset", 7, 7, 7, 1'b1, 4'd7);

    // Bouncing box: after 303 strobes X=606 (INC), Y=290 (DEC)
    apply_stimulus(4'd8, 0, 0, 1'b0, 1'b1);
    while (strobe_count < 303) apply_stimulus(4'd8, 0, 0, 1'b0, 1'b1);
`ifdef VIDEO_PATTERN_GEN_BOX_EN
    apply_stimulus(4'd8, 606, 290, 1'b1, 1'b0);
    check_output("box_x606_corner", 7, 7, 7, 1'b1, 4'd8);
    apply_stimulus(4'd8, 605, 300, 1'b1, 1'b0);
    check_output("box_x606_left_out", 0, 0, 0, 1'b1, 4'd8);
    apply_stimulus(4'd8, 620, 289, 1'b1, 1'b0);
    check_output("box_y290_above", 0, 0, 0, 1'b1, 4'd8);
    apply_stimulus(4'd8, 620, 321, 1'b1, 1'b0);
    check_output("box_y290_last_row", 7, 7, 7, 1'b1, 4'd8);
    apply_stimulus(4'd8, 620, 322, 1'b1, 1'b0);
    check_output("box_y290_below", 0, 0, 0, 1'b1, 4'd8);
    // X clamps to 608 and turns around, Y=288
    apply_stimulus(4'd8, 0, 0, 1'b0, 1'b1);
    apply_stimulus(4'd8, 607, 300, 1'b1, 1'b0);
    check_output("box_x608_left_out", 0, 0, 0, 1'b1, 4'd8);
    apply_stimulus(4'd8, 608, 288, 1'b1, 1'b0);
    check_output("box_x608_corner", 7, 7, 7, 1'b1, 4'd8);
    apply_stimulus(4'd8, 639, 319, 1'b1, 1'b0);
    check_output("box_x608_far_corner", 7, 7, 7, 1'b1, 4'd8);
    apply_stimulus(4'd8, 620, 320, 1'b1, 1'b0);
    check_output("box_y288_below", 0, 0, 0, 1'b1, 4'd8);
    // Moving back: X=606, Y=286
    apply_stimulus(4'd8, 0, 0, 1'b0, 1'b1);
    apply_stimulus(4'd8, 606, 286, 1'b1, 1'b0);
    check_output("box_x606_dec_corner", 7, 7, 7, 1'b1, 4'd8);
    apply_stimulus(4'd8, 638, 300, 1'b1, 1'b0);
    check_output("box_x606_dec_right_out", 0, 0, 0, 1'b1, 4'd8);
`else
    apply_stimulus(4'd8, 606, 290, 1'b1, 1'b0);
    check_output("box_disabled_a", 0, 0, 0, 1'b1, 4'd8);
    apply_stimulus(4'd8, 620, 300, 1'b1, 1'b0);
    check_output("box_disabled_b", 0, 0, 0, 1'b1, 4'd8);
    apply_stimulus(4'd8, 0, 0, 1'b0, 1'b1);
    apply_stimulus(4'd8, 620, 300, 1'b1, 1'b0);
    check_output("box_disabled_c", 0, 0, 0, 1'b1, 4'd8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
